fifo_rd_ctrl: RTL and testbench

Read-side controller for the FIFO. It owns the read pointer into the dual-port FIFO RAM and issues RAM reads. It detects empty against the write pointer already synchronized into its clock domain, and returns words to the consumer through a 2-entry valid/ready output buffer. It is the consumer-facing counterpart of the write-side logic and sustains one word per cycle once primed.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_out_buf.sv | 68 ++++++
 rtl/fifo_rd_ctrl.sv | 83 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and Gray/binary pointer conversions.
// Used by both the read-side and write-side controllers.
//   FIFO_DATA_WIDTH / FIFO_ADDR_WIDTH : default word width / RAM address width
//   bin2gray / gray2bin                : width-agnostic conversions; callers
//                                        zero-extend into 32 bits and truncate
//                                        the result back to their pointer width
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Leading zeros of a zero-extended operand stay zero in both directions,
  // so one 32-bit implementation serves any pointer width up to 32.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order valid/ready output buffer.
//   clk, rst         : clock, synchronous active-high reset
//   push, data_in    : write a word (caller guarantees never when full)
//   pop              : head word consumed this cycle
//   occ              : entries held, 0..2
//   dout, dout_valid : head entry and its valid flag
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = data_in;
        else               ent1_d = data_in;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // pop implies occ >= 1; the new word lands behind whatever remains
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = data_in;
        end else begin
          ent0_d = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign occ        = occ_q;
  assign dout       = ent0_q;
  assign dout_valid = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: owns the read pointer, detects empty against the
// synchronized write pointer, fetches RAM words and hands them to the consumer
// through a 2-entry valid/ready buffer at up to one word per cycle.
//   r_clk, r_rst       : read clock, synchronous active-high reset
//   rq2_wptr           : Gray write pointer already synchronized to r_clk
//   raddr, rdata       : RAM read port (rdata = MEM[raddr] one edge later)
//   rptr               : registered Gray read pointer for the write domain
//   rempty             : registered, RAM holds no unread words
//   rcount             : words still in RAM (not in flight, not buffered)
//   dout, dout_valid,
//   dout_ready         : consumer handshake
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rcount,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin_q, rbin_d, rptr_q, rptr_d;
  logic          rempty_q, rempty_d, inflight_q, inflight_d;
  logic [1:0]    occ;
  logic          pop, fire;

  always_comb begin
    pop        = dout_valid && dout_ready;
    // occ + inflight - pop < 2, with pop moved across so nothing goes negative.
    // This bound also keeps occ <= 1 whenever a word lands, so the buffer
    // can never be pushed while full.
    fire       = !rempty_q &&
                 (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    rbin_d     = rbin_q + PW'(fire);
    rptr_d     = PW'(bin2gray(32'(rbin_d)));
    rempty_d   = (rptr_d == rq2_wptr);
    inflight_d = fire;
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      inflight_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      inflight_q <= inflight_d;
    end
  end

  // The word fetched last cycle is on rdata now; it is captured at this edge.
  fifo_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk        (r_clk),
    .rst        (r_rst),
    .push       (inflight_q),
    .data_in    (rdata),
    .pop        (pop),
    .occ        (occ),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  assign raddr  = rbin_q[ADDR_WIDTH-1:0];
  assign rptr   = rptr_q;
  assign rempty = rempty_q;
  // Modulo-2^PW difference handles lap wrap of both pointers.
  assign rcount = PW'(gray2bin(32'(rq2_wptr))) - rbin_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [4:0] rq2_wptr = 5'd0;
  logic [3:0] raddr;
  logic [7:0] rdata = 8'd0;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rcount;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .rq2_wptr(rq2_wptr), .raddr(raddr),
    .rdata(rdata), .rptr(rptr), .rempty(rempty), .rcount(rcount),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0] mem [16];
  always @(posedge r_clk) rdata <= mem[raddr];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [4:0] wbin = 5'd0;
  logic [7:0] seq_data = 8'h00;
  int         rcv_cnt = 0;
  int         fire_cnt = 0;
  bit         hold_prev = 0;
  logic [7:0] prev_dout = 8'd0;
  logic [4:0] prev_rbin = 5'd0;
  logic [3:0] prev_raddr = 4'd0;
  bit         rbin_wrapped = 0;
  bit         raddr_wrapped = 0;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] x);
    logic [4:0] b;
    b[4] = x[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ x[i];
    return b;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  // Write-side model: store word, push to scoreboard, publish pointer.
  task automatic write_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
    rq2_wptr = g(wbin);
  endtask

  task automatic wait_drain(input string nm);
    int cyc = 0;
    while ((exp_q.size() != 0 || dout_valid) && cyc < 300) begin
      tick();
      cyc++;
    end
    check({nm, "_drain_timeout"}, int'(cyc < 300), 1);
  endtask

  // Writer fills free RAM space, reader drives dout_ready; toggling or random.
  task automatic stream(input string nm, input int n, input bit rnd);
    int sent = 0;
    int cyc = 0;
    int start = rcv_cnt;
    logic [4:0] used;
    while ((rcv_cnt - start) < n && cyc < 30000) begin
      used = wbin - g2b(rptr);
      if (sent < n && used < 5'd16 && (!rnd || $urandom_range(0, 1) == 1)) begin
        write_word(seq_data);
        seq_data = seq_data + 8'd1;
        sent++;
      end
      dout_ready = rnd ? ($urandom_range(0, 3) != 0) : ~dout_ready;
      tick();
      cyc++;
    end
    check({nm, "_received"}, rcv_cnt - start, n);
  endtask

  // Monitor: scoreboard pop/compare, stall stability, overflow, wrap tracking.
  always @(negedge r_clk) begin
    if (r_rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", int'(dout_valid), 1);
        check("hold_dout", int'(dout), int'(prev_dout));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", int'(dout), -1);
        end else begin
          check("dout_data", int'(dout), int'(exp_q.pop_front()));
        end
        rcv_cnt++;
      end
      if (dut.u_buf.push) check("buf_overflow", int'(dut.u_buf.occ == 2'd2), 0);
      if (dut.fire) fire_cnt++;
      if (prev_rbin == 5'd31 && dut.rbin_q == 5'd0) rbin_wrapped = 1;
      if (prev_raddr == 4'd15 && raddr == 4'd0) raddr_wrapped = 1;
      hold_prev  = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_rbin  = dut.rbin_q;
      prev_raddr = raddr;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset and idle
    tick();
    tick();
    check("rst_rempty", int'(rempty), 1);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_rptr", int'(rptr), 0);
    r_rst = 1'b0;
    fire_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_rempty", int'(rempty), 1);
      check("idle_dout_valid", int'(dout_valid), 0);
      check("idle_rptr", int'(rptr), 0);
      check("idle_raddr", int'(raddr), 0);
      check("idle_rcount", int'(rcount), 0);
    end
    check("idle_fires", fire_cnt, 0);

    // Three words, consumer always ready
    dout_ready = 1'b1;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    check("w3_wptr_gray", int'(rq2_wptr), int'(5'b00010));
    tick();                                   // cycle N: first fetch
    check("w3_rempty_fell", int'(rempty), 0);
    check("w3_valid_N", int'(dout_valid), 0);
    tick();
    check("w3_valid_N1", int'(dout_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w3_valid_burst", int'(dout_valid), 1);
    end
    tick();
    check("w3_valid_drop", int'(dout_valid), 0);
    check("w3_rempty_end", int'(rempty), 1);
    check("w3_rptr_end", int'(rptr), int'(5'b00010));
    check("w3_all_seen", exp_q.size(), 0);

    // Full RAM with a stalled consumer
    dout_ready = 1'b0;
    fire_cnt = 0;
    for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i));
    for (int i = 0; i < 10; i++) tick();
    check("full_fires", fire_cnt, 2);
    check("full_occ", int'(dut.u_buf.occ), 2);
    check("full_rcount", int'(rcount), 14);
    check("full_dout", int'(dout), 8'h40);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("full_no_gap", int'(dout_valid), 1);
      tick();
    end
    check("full_drained_valid", int'(dout_valid), 0);
    check("full_all_seen", exp_q.size(), 0);

    // 40 words with dout_ready toggling; pointers lap
    rbin_wrapped = 0;
    raddr_wrapped = 0;
    seq_data = 8'h80;
    stream("toggle40", 40, 1'b0);
    dout_ready = 1'b1;
    wait_drain("toggle40");
    check("rbin_wrap", int'(rbin_wrapped), 1);
    check("raddr_wrap", int'(raddr_wrapped), 1);

    // Reset with two words buffered while a third is being fetched
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'hC0 + 8'(i));
    begin
      int cyc = 0;
      while (dut.u_buf.occ != 2'd2 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("pre_rst_occ", int'(dut.u_buf.occ), 2);
    end
    dout_ready = 1'b1;                        // this cycle pops and fires
    r_rst = 1'b1;
    wbin = 5'd0;
    rq2_wptr = 5'd0;
    exp_q.delete();
    tick();
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_rbin", int'(dut.rbin_q), 0);
    check("mid_rst_rptr", int'(rptr), 0);
    check("mid_rst_rempty", int'(rempty), 1);
    check("mid_rst_rcount", int'(rcount), 0);
    r_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_stale", int'(dout_valid), 0);
    end
    write_word(8'h77);
    write_word(8'h88);
    wait_drain("post_rst");

    // Random producer/consumer against the scoreboard
    stream("random", 4000, 1'b1);
    dout_ready = 1'b1;
    wait_drain("random");
    check("random_empty", int'(rempty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
